// File: rtl/decode_stage.sv
// Decode stage: 2-read/1-write register file with write bypass, immediate
// extension and jump-target formation, followed by a stall/flush pipeline register.
module decode_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREG    = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned JADDR_W = 26,
  localparam int unsigned ADDR_W = $clog2(NREG),
  localparam int unsigned PCH_W  = DATA_W - JADDR_W - 2
) (
  input  logic               reloj,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  DIR_A,
  input  logic [ADDR_W-1:0]  DIR_B,
  input  logic [ADDR_W-1:0]  DIR_WRA,
  input  logic [DATA_W-1:0]  DI,
  input  logic               REG_WR,
  input  logic               REG_RD,
  input  logic               SEL_I,
  input  logic [IMM_W-1:0]   IMD,
  input  logic [JADDR_W-1:0] address,
  input  logic [PCH_W-1:0]   PC_4,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [DATA_W-1:0]  DOA,
  output logic [DATA_W-1:0]  DOB,
  output logic [DATA_W-1:0]  out_mux_sz,
  output logic [DATA_W-1:0]  out_addr,
  output logic               out_valid
);

  localparam int unsigned EXT_W = DATA_W - IMM_W;

  logic [DATA_W-1:0] regs [NREG];

  logic              wr_en_c;
  logic [DATA_W-1:0] rd_a_c;
  logic [DATA_W-1:0] rd_b_c;
  logic [DATA_W-1:0] ext_c;
  logic [DATA_W-1:0] jaddr_c;

  // Writes to r0 are dropped so it stays hard-wired to zero.
  assign wr_en_c = !REG_WR && (DIR_WRA != '0);

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs[DIR_WRA] <= DI;
    end
  end

  // Read ports: disabled reads give zero, same-cycle writes forward DI.
  always_comb begin
    rd_a_c = '0;
    rd_b_c = '0;
    if (!REG_RD) begin
      if (DIR_A != '0) begin
        rd_a_c = (wr_en_c && (DIR_WRA == DIR_A)) ? DI : regs[DIR_A];
      end
      if (DIR_B != '0) begin
        rd_b_c = (wr_en_c && (DIR_WRA == DIR_B)) ? DI : regs[DIR_B];
      end
    end
  end

  always_comb begin
    ext_c   = {{EXT_W{SEL_I & IMD[IMM_W-1]}}, IMD};
    jaddr_c = {PC_4, address, 2'b00};
  end

  // Output register: flush beats stall beats load.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      DOA        <= '0;
      DOB        <= '0;
      out_mux_sz <= '0;
      out_addr   <= '0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      DOA        <= '0;
      DOB        <= '0;
      out_mux_sz <= '0;
      out_addr   <= '0;
      out_valid  <= 1'b0;
    end else if (!stall) begin
      DOA        <= rd_a_c;
      DOB        <= rd_b_c;
      out_mux_sz <= ext_c;
      out_addr   <= jaddr_c;
      out_valid  <= in_valid;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic        reloj;
  logic        reset;
  logic [4:0]  DIR_A, DIR_B, DIR_WRA;
  logic [31:0] DI;
  logic        REG_WR, REG_RD, SEL_I;
  logic [15:0] IMD;
  logic [25:0] address;
  logic [3:0]  PC_4;
  logic        in_valid, stall, flush;
  logic [31:0] DOA, DOB, out_mux_sz, out_addr;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .reloj(reloj), .reset(reset),
    .DIR_A(DIR_A), .DIR_B(DIR_B), .DIR_WRA(DIR_WRA), .DI(DI),
    .REG_WR(REG_WR), .REG_RD(REG_RD), .SEL_I(SEL_I), .IMD(IMD),
    .address(address), .PC_4(PC_4), .in_valid(in_valid),
    .stall(stall), .flush(flush),
    .DOA(DOA), .DOB(DOB), .out_mux_sz(out_mux_sz), .out_addr(out_addr),
    .out_valid(out_valid)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  task automatic idle();
    REG_WR = 1'b1; REG_RD = 1'b0; SEL_I = 1'b0;
    DIR_A = 5'd0; DIR_B = 5'd0; DIR_WRA = 5'd0; DI = 32'h0;
    IMD = 16'h0; address = 26'h0; PC_4 = 4'h0;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #2;
    check("rst_doa", DOA, 32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    tick();
    #2 reset = 1'b0;

    // Write r5, then read it back through port A.
    REG_WR = 1'b0; DIR_WRA = 5'd5; DI = 32'hDEADBEEF;
    tick();
    idle(); DIR_A = 5'd5; in_valid = 1'b1;
    tick();
    check("r5_doa", DOA, 32'hDEADBEEF);
    check("r5_valid", {31'h0, out_valid}, 32'h1);

    // r0 write ignored.
    idle(); REG_WR = 1'b0; DIR_WRA = 5'd0; DI = 32'h12345678; DIR_A = 5'd0;
    tick();
    check("r0_doa", DOA, 32'h0);

    // Same-cycle write/read bypass on port B.
    idle(); REG_WR = 1'b0; DIR_WRA = 5'd7; DI = 32'hA5A5A5A5; DIR_A = 5'd5; DIR_B = 5'd7;
    tick();
    check("byp_dob", DOB, 32'hA5A5A5A5);
    check("byp_doa", DOA, 32'hDEADBEEF);
    idle(); DIR_B = 5'd7;
    tick();
    check("r7_stored", DOB, 32'hA5A5A5A5);

    // Bypass on both ports at once.
    idle(); REG_WR = 1'b0; DIR_WRA = 5'd9; DI = 32'h11112222; DIR_A = 5'd9; DIR_B = 5'd9;
    tick();
    check("byp2_doa", DOA, 32'h11112222);
    check("byp2_dob", DOB, 32'h11112222);

    // Immediate extension and jump target.
    idle(); IMD = 16'h8001; SEL_I = 1'b1; PC_4 = 4'hA; address = 26'h3FFFFFF;
    tick();
    check("sext_neg", out_mux_sz, 32'hFFFF8001);
    check("jaddr", out_addr, 32'hAFFFFFFC);
    SEL_I = 1'b0;
    tick();
    check("zext_neg", out_mux_sz, 32'h00008001);
    IMD = 16'h7FFF; SEL_I = 1'b1;
    tick();
    check("sext_pos", out_mux_sz, 32'h00007FFF);

    // Load a valid op, then stall three cycles with changing inputs and a write.
    idle(); DIR_A = 5'd5; DIR_B = 5'd7; in_valid = 1'b1; IMD = 16'h1234; PC_4 = 4'h1; address = 26'h10;
    tick();
    check("ld_doa", DOA, 32'hDEADBEEF);
    check("ld_addr", out_addr, 32'h10000040);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; in_valid = 1'b0; DIR_A = 5'(i + 1); DIR_B = 5'd0;
      IMD = 16'(16'hF000 + i); SEL_I = 1'b1; PC_4 = 4'hF;
      REG_WR = (i != 0); DIR_WRA = 5'd3; DI = 32'h00000033;
      tick();
      check("stl_doa", DOA, 32'hDEADBEEF);
      check("stl_dob", DOB, 32'hA5A5A5A5);
      check("stl_imm", out_mux_sz, 32'h00001234);
      check("stl_valid", {31'h0, out_valid}, 32'h1);
    end
    REG_WR = 1'b1; flush = 1'b1;
    tick();
    check("fl_valid", {31'h0, out_valid}, 32'h0);
    check("fl_doa", DOA, 32'h0);
    check("fl_imm", out_mux_sz, 32'h0);
    check("fl_addr", out_addr, 32'h0);

    // Write during stall landed.
    idle(); DIR_A = 5'd3; in_valid = 1'b1;
    tick();
    check("stl_write", DOA, 32'h00000033);

    // Read disable forces zero; in_valid=0 loads a bubble.
    idle(); REG_RD = 1'b1; DIR_A = 5'd5; DIR_B = 5'd7;
    tick();
    check("rd_off_doa", DOA, 32'h0);
    check("rd_off_dob", DOB, 32'h0);
    check("bubble_valid", {31'h0, out_valid}, 32'h0);

    // Asynchronous reset between edges, write attempt while in reset.
    idle(); DIR_A = 5'd5; DIR_B = 5'd7; in_valid = 1'b1;
    tick();
    check("pre_rst_doa", DOA, 32'hDEADBEEF);
    #2 reset = 1'b1;
    #1;
    check("async_doa", DOA, 32'h0);
    check("async_dob", DOB, 32'h0);
    check("async_valid", {31'h0, out_valid}, 32'h0);
    REG_WR = 1'b0; DIR_WRA = 5'd5; DI = 32'hFFFFFFFF;
    @(posedge reloj);
    #2 reset = 1'b0;
    idle(); DIR_A = 5'd5; DIR_B = 5'd7; in_valid = 1'b1;
    tick();
    check("post_rst_r5", DOA, 32'h0);
    check("post_rst_r7", DOB, 32'h0);
    check("post_rst_valid", {31'h0, out_valid}, 32'h1);
    DIR_A = 5'd3; DIR_B = 5'd9;
    tick();
    check("post_rst_r3", DOA, 32'h0);
    check("post_rst_r9", DOB, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
